bus_arbiter: RTL and testbench
==============================

BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255: maximum slave waitrequest-high cycles per granted transfer.
REQ-002 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port m0_address  input  32  instruction-fetch master word address.
REQ-005 SHALL have port m0_read  input  1  instruction-fetch read request.
REQ-006 SHALL have port m0_waitrequest  output  1  stall to fetch master.
REQ-007 SHALL have port m0_readdata  output  32  read data to fetch master.
REQ-008 SHALL have port m1_address  input  32  data master word address.
REQ-009 SHALL have port m1_read  input  1  data master read request.
REQ-010 SHALL have port m1_write  input  1  data master write request.
REQ-011 SHALL have port m1_writedata  input  32  data master write data.
REQ-012 SHALL have port m1_byteenable  input  4  data master byte lanes.
REQ-013 SHALL have port m1_waitrequest  output  1  stall to data master.
REQ-014 SHALL have port m1_readdata  output  32  read data to data master.
REQ-015 SHALL have port address  output  32  Avalon slave address.
REQ-016 SHALL have port read  output  1  Avalon slave read.
REQ-017 SHALL have port write  output  1  Avalon slave write.
REQ-018 SHALL have port writedata  output  32  Avalon slave write data.
REQ-019 SHALL have port byteenable  output  4  Avalon slave byte lanes.
REQ-020 SHALL have port waitrequest  input  1  Avalon slave stall.
REQ-021 SHALL have port readdata  input  32  Avalon slave read data.
REQ-022 SHALL have port grant  output  2  one-hot current owner (bit0 m0, bit1 m1), 0 when idle.
REQ-023 SHALL have port timeout_err  output  1  sticky flag, set on any transfer timeout.

Function
REQ-024 SHALL implement states IDLE, GRANT0, GRANT1.
REQ-025 SHALL, in IDLE, drive read=write=0, byteenable=0, grant=0, and both master waitrequests=1.
REQ-026 SHALL leave IDLE on the next edge when any request (m0_read, m1_read|m1_write) is high; a lone requester is granted.
REQ-027 SHALL, on simultaneous requests, grant the master not served last (round-robin); last-served pointer resets to m1, so m0 wins the first tie.
REQ-028 SHALL, in GRANTn, pass master n address/read/write/writedata/byteenable to the slave combinationally; m0 drives write=0, byteenable=4'b1111.
REQ-029 SHALL drive granted master waitrequest = slave waitrequest; non-granted master waitrequest=1 always.
REQ-030 SHALL broadcast slave readdata to both m0_readdata and m1_readdata.
REQ-031 SHALL complete a transfer on the edge where granted request is high and slave waitrequest=0, and update the last-served pointer.
REQ-032 SHALL, on completion, go directly to the other GRANT state if the other master requests, else to the same GRANT if it still requests and the other does not, else IDLE (no idle bubble).
REQ-033 SHALL return to IDLE if the granted master drops its request before completion, issuing no completion.
REQ-034 SHALL count consecutive granted cycles with slave waitrequest=1; counter clears on completion and on grant change.
REQ-035 SHALL, when the counter reaches TIMEOUT_CYCLES, set timeout_err, force granted waitrequest=0 for that cycle, and return to IDLE.
REQ-036 SHALL clear timeout_err only by reset.

Reset
REQ-037 SHALL, on reset low, immediately enter IDLE, clear the counter and timeout_err, and set the last-served pointer to m1, including mid-transfer.
REQ-038 SHALL, while reset is low, hold all outputs at IDLE values (REQ-025) with readdata passthrough.

Structure
REQ-039 SHALL take the state enum and TIMEOUT_CYCLES default from shared package bus_pkg.
REQ-040 SHALL place the timeout counter in sub-module bus_timeout_counter.

Verification
REQ-041 SHALL test: m0_read only, address 0xBFC00000, slave waitrequest low after 2 cycles -> grant=01, m0 receives readdata 0x24020005, returns IDLE.
REQ-042 SHALL test: m0_read and m1_write (data 0xDEADBEEF, byteenable 0011) together from reset -> m0 served first, then m1 back-to-back with no IDLE cycle.
REQ-043 SHALL test: continuous requests from both masters for 6 transfers -> grant alternates 01,10,01,10,01,10.
REQ-044 SHALL test: slave waitrequest stuck high with TIMEOUT_CYCLES=4 -> timeout_err=1 after 4 stalled cycles, m1_waitrequest low one cycle, IDLE.
REQ-045 SHALL test: reset asserted mid-GRANT1 stall -> read=write=0, grant=00 without a clock edge; m0 wins the first post-reset tie.

Source files
------------

// File: rtl/bus_pkg.sv
// Shared types and defaults for the two-master Avalon bus arbiter.
package bus_pkg;

  localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 255;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } state_t;

  typedef enum logic {
    OWNER_M0 = 1'b0,
    OWNER_M1 = 1'b1
  } owner_t;

  function automatic logic [1:0] grant_of(input state_t s);
    logic [1:0] g;
    g = 2'b00;
    case (s)
      GRANT0:  g = 2'b01;
      GRANT1:  g = 2'b10;
      default: g = 2'b00;
    endcase
    return g;
  endfunction

  function automatic int unsigned count_width(input int unsigned limit);
    return (limit < 2) ? 1 : $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/bus_arbiter_if.sv
// Bus bundle between the fetch master (m0), data master (m1), the arbiter and the Avalon slave.
interface bus_arbiter_if;

  logic [31:0] m0_address;
  logic        m0_read;
  logic        m0_waitrequest;
  logic [31:0] m0_readdata;

  logic [31:0] m1_address;
  logic        m1_read;
  logic        m1_write;
  logic [31:0] m1_writedata;
  logic [3:0]  m1_byteenable;
  logic        m1_waitrequest;
  logic [31:0] m1_readdata;

  logic [31:0] address;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [3:0]  byteenable;
  logic        waitrequest;
  logic [31:0] readdata;

  // master: the environment (requesting masters plus the slave device); slave: the arbiter
  modport master (
    output m0_address, m0_read,
    input  m0_waitrequest, m0_readdata,
    output m1_address, m1_read, m1_write, m1_writedata, m1_byteenable,
    input  m1_waitrequest, m1_readdata,
    input  address, read, write, writedata, byteenable,
    output waitrequest, readdata
  );

  modport slave (
    input  m0_address, m0_read,
    output m0_waitrequest, m0_readdata,
    input  m1_address, m1_read, m1_write, m1_writedata, m1_byteenable,
    output m1_waitrequest, m1_readdata,
    output address, read, write, writedata, byteenable,
    input  waitrequest, readdata
  );

endinterface

// File: rtl/bus_timeout_counter.sv
// Counts consecutive stalled cycles of the current grant; expired flags the limit.
module bus_timeout_counter
  import bus_pkg::*;
#(
  parameter int unsigned LIMIT = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic stall,
  output logic expired
);

  localparam int unsigned    CW        = count_width(LIMIT);
  localparam logic [CW-1:0]  LIMIT_VAL = CW'(LIMIT);

  logic [CW-1:0] count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (stall && !expired) begin
      count <= count + 1'b1;
    end
  end

  assign expired = (count == LIMIT_VAL);

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin arbiter sharing one Avalon slave between a fetch master and a data master.
module bus_arbiter
  import bus_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic             clk,
  input  logic             reset,
  bus_arbiter_if.slave     bus,
  output logic [1:0]       grant,
  output logic             timeout_err
);

  state_t state, state_next;
  owner_t last, last_next;
  logic   req0, req1;
  logic   cnt_clear, expired, timeout;

  assign req0 = bus.m0_read;
  assign req1 = bus.m1_read | bus.m1_write;

  bus_timeout_counter #(
    .LIMIT(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (clk),
    .reset  (reset),
    .clear  (cnt_clear),
    .stall  (bus.waitrequest),
    .expired(expired)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      last        <= OWNER_M1;
      timeout_err <= 1'b0;
    end else begin
      state <= state_next;
      last  <= last_next;
      if (timeout) timeout_err <= 1'b1;
    end
  end

  // The counter only keeps running on a stalled cycle that keeps the same grant;
  // every other outcome (completion, drop, timeout, idle) clears it.
  always_comb begin
    state_next = state;
    last_next  = last;
    timeout    = 1'b0;
    cnt_clear  = 1'b1;

    bus.address        = '0;
    bus.read           = 1'b0;
    bus.write          = 1'b0;
    bus.writedata      = '0;
    bus.byteenable     = '0;
    bus.m0_waitrequest = 1'b1;
    bus.m1_waitrequest = 1'b1;

    case (state)
      IDLE: begin
        if (req0 && req1) begin
          state_next = (last == OWNER_M1) ? GRANT0 : GRANT1;
        end else if (req0) begin
          state_next = GRANT0;
        end else if (req1) begin
          state_next = GRANT1;
        end
      end

      GRANT0: begin
        bus.address        = bus.m0_address;
        bus.read           = bus.m0_read;
        bus.byteenable     = '1;
        bus.m0_waitrequest = bus.waitrequest & ~expired;
        if (expired) begin
          timeout    = 1'b1;
          state_next = IDLE;
        end else if (!req0) begin
          state_next = IDLE;
        end else if (!bus.waitrequest) begin
          last_next  = OWNER_M0;
          state_next = req1 ? GRANT1 : GRANT0;
        end else begin
          cnt_clear = 1'b0;
        end
      end

      GRANT1: begin
        bus.address        = bus.m1_address;
        bus.read           = bus.m1_read;
        bus.write          = bus.m1_write;
        bus.writedata      = bus.m1_writedata;
        bus.byteenable     = bus.m1_byteenable;
        bus.m1_waitrequest = bus.waitrequest & ~expired;
        if (expired) begin
          timeout    = 1'b1;
          state_next = IDLE;
        end else if (!req1) begin
          state_next = IDLE;
        end else if (!bus.waitrequest) begin
          last_next  = OWNER_M1;
          state_next = req0 ? GRANT0 : GRANT1;
        end else begin
          cnt_clear = 1'b0;
        end
      end

      default: state_next = IDLE;
    endcase
  end

  assign bus.m0_readdata = bus.readdata;
  assign bus.m1_readdata = bus.readdata;
  assign grant           = grant_of(state);

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed self-checking bench for bus_arbiter, built with a 4-cycle timeout.
module tb_bus_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] grant;
  logic       timeout_err;
  int         n_assert = 0;
  int         n_fail   = 0;

  bus_arbiter_if bif ();

  bus_arbiter #(
    .TIMEOUT_CYCLES(4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bif),
    .grant      (grant),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset              = 1'b0;
    bif.m0_address     = '0;
    bif.m0_read        = 1'b0;
    bif.m1_address     = '0;
    bif.m1_read        = 1'b0;
    bif.m1_write       = 1'b0;
    bif.m1_writedata   = '0;
    bif.m1_byteenable  = '0;
    bif.waitrequest    = 1'b0;
    bif.readdata       = 32'h1234_5678;
    tick;
    tick;

    check("rst_grant",   32'(grant), 32'h0);
    check("rst_read",    32'(bif.read), 32'h0);
    check("rst_write",   32'(bif.write), 32'h0);
    check("rst_be",      32'(bif.byteenable), 32'h0);
    check("rst_m0_wait", 32'(bif.m0_waitrequest), 32'h1);
    check("rst_m1_wait", 32'(bif.m1_waitrequest), 32'h1);
    check("rst_err",     32'(timeout_err), 32'h0);
    check("rst_m0_rd",   bif.m0_readdata, 32'h1234_5678);
    check("rst_m1_rd",   bif.m1_readdata, 32'h1234_5678);
    reset = 1'b1;

    // lone fetch read, slave stalls two cycles
    bif.m0_address  = 32'hBFC0_0000;
    bif.m0_read     = 1'b1;
    bif.waitrequest = 1'b1;
    #1;
    check("t1_idle_grant", 32'(grant), 32'h0);
    tick;
    check("t1_grant",   32'(grant), 32'h1);
    check("t1_read",    32'(bif.read), 32'h1);
    check("t1_addr",    bif.address, 32'hBFC0_0000);
    check("t1_be",      32'(bif.byteenable), 32'hF);
    check("t1_write",   32'(bif.write), 32'h0);
    check("t1_m0_wait", 32'(bif.m0_waitrequest), 32'h1);
    check("t1_m1_wait", 32'(bif.m1_waitrequest), 32'h1);
    tick;
    check("t1_m0_wait2", 32'(bif.m0_waitrequest), 32'h1);
    bif.waitrequest = 1'b0;
    bif.readdata    = 32'h2402_0005;
    #1;
    check("t1_m0_done", 32'(bif.m0_waitrequest), 32'h0);
    check("t1_rdata",   bif.m0_readdata, 32'h2402_0005);
    check("t1_grant3",  32'(grant), 32'h1);
    tick;
    bif.m0_read = 1'b0;
    #1;
    check("t1_read_drop", 32'(bif.read), 32'h0);
    tick;
    check("t1_back_idle", 32'(grant), 32'h0);
    check("t1_idle_wait", 32'(bif.m0_waitrequest), 32'h1);

    // simultaneous requests straight after reset: m0 then m1, no idle gap
    reset = 1'b0;
    #1;
    reset = 1'b1;
    bif.m0_address    = 32'h0000_0100;
    bif.m0_read       = 1'b1;
    bif.m1_address    = 32'h0000_0200;
    bif.m1_write      = 1'b1;
    bif.m1_writedata  = 32'hDEAD_BEEF;
    bif.m1_byteenable = 4'b0011;
    #1;
    check("t2_idle", 32'(grant), 32'h0);
    tick;
    check("t2_g0",      32'(grant), 32'h1);
    check("t2_g0_addr", bif.address, 32'h0000_0100);
    check("t2_g0_wr",   32'(bif.write), 32'h0);
    check("t2_g0_be",   32'(bif.byteenable), 32'hF);
    check("t2_m0_wait", 32'(bif.m0_waitrequest), 32'h0);
    check("t2_m1_hold", 32'(bif.m1_waitrequest), 32'h1);
    tick;
    bif.m0_read = 1'b0;
    #1;
    check("t2_g1",      32'(grant), 32'h2);
    check("t2_g1_addr", bif.address, 32'h0000_0200);
    check("t2_g1_wr",   32'(bif.write), 32'h1);
    check("t2_g1_rd",   32'(bif.read), 32'h0);
    check("t2_g1_wdat", bif.writedata, 32'hDEAD_BEEF);
    check("t2_g1_be",   32'(bif.byteenable), 32'h3);
    check("t2_m1_wait", 32'(bif.m1_waitrequest), 32'h0);
    check("t2_m0_hold", 32'(bif.m0_waitrequest), 32'h1);
    tick;
    bif.m1_write = 1'b0;
    #1;
    check("t2_wr_drop", 32'(bif.write), 32'h0);
    tick;
    check("t2_end_idle", 32'(grant), 32'h0);

    // both masters requesting continuously: strict alternation
    bif.m0_address = 32'h0000_0010;
    bif.m1_address = 32'h0000_0020;
    bif.m0_read    = 1'b1;
    bif.m1_read    = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick;
      check($sformatf("t3_grant%0d", i), 32'(grant), (i % 2 == 0) ? 32'h1 : 32'h2);
      check($sformatf("t3_addr%0d", i), bif.address, (i % 2 == 0) ? 32'h10 : 32'h20);
    end
    bif.m0_read = 1'b0;
    bif.m1_read = 1'b0;
    tick;
    check("t3_end_idle", 32'(grant), 32'h0);

    // slave stuck in waitrequest: timeout after 4 stalled cycles
    bif.m1_address  = 32'h0000_0300;
    bif.m1_read     = 1'b1;
    bif.waitrequest = 1'b1;
    tick;
    check("t4_grant", 32'(grant), 32'h2);
    check("t4_wait0", 32'(bif.m1_waitrequest), 32'h1);
    for (int i = 1; i < 4; i++) begin
      tick;
      check($sformatf("t4_wait%0d", i), 32'(bif.m1_waitrequest), 32'h1);
      check($sformatf("t4_err%0d", i), 32'(timeout_err), 32'h0);
    end
    tick;
    check("t4_forced", 32'(bif.m1_waitrequest), 32'h0);
    check("t4_grant5", 32'(grant), 32'h2);
    check("t4_err_pre", 32'(timeout_err), 32'h0);
    tick;
    bif.m1_read = 1'b0;
    #1;
    check("t4_err_set", 32'(timeout_err), 32'h1);
    check("t4_idle",    32'(grant), 32'h0);
    check("t4_idle_wt", 32'(bif.m1_waitrequest), 32'h1);
    tick;
    check("t4_sticky", 32'(timeout_err), 32'h1);

    // reset during a stalled m1 write; pointer returns to m1 so m0 wins the tie
    bif.m1_address    = 32'h0000_0400;
    bif.m1_write      = 1'b1;
    bif.m1_writedata  = 32'h0BAD_F00D;
    bif.m1_byteenable = 4'hF;
    tick;
    check("t5_grant", 32'(grant), 32'h2);
    check("t5_write", 32'(bif.write), 32'h1);
    tick;
    reset        = 1'b0;
    bif.readdata = 32'hCAFE_F00D;
    #1;
    check("t5_rst_write", 32'(bif.write), 32'h0);
    check("t5_rst_read",  32'(bif.read), 32'h0);
    check("t5_rst_grant", 32'(grant), 32'h0);
    check("t5_rst_be",    32'(bif.byteenable), 32'h0);
    check("t5_rst_err",   32'(timeout_err), 32'h0);
    check("t5_rst_m1wt",  32'(bif.m1_waitrequest), 32'h1);
    check("t5_rst_m0wt",  32'(bif.m0_waitrequest), 32'h1);
    check("t5_rst_rdata", bif.m1_readdata, 32'hCAFE_F00D);
    bif.m0_address = 32'h0000_0500;
    bif.m0_read    = 1'b1;
    tick;
    check("t5_hold_idle", 32'(grant), 32'h0);
    reset = 1'b1;
    #1;
    check("t5_rel_idle", 32'(grant), 32'h0);
    tick;
    check("t5_tie_m0", 32'(grant), 32'h1);
    check("t5_addr",   bif.address, 32'h0000_0500);

    bif.m0_read  = 1'b0;
    bif.m1_write = 1'b0;
    tick;
    tick;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
